// File: rtl/mpsk_qam_mapper_pkg.sv
// Shared types and constants for the BPSK/QPSK/16QAM bit-to-symbol mapper.
// Mode encoding, bits-per-symbol lookup and default amplitude levels.
package mpsk_qam_mapper_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_QAM16 = 2'b10
    } mode_e;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_AMP_PSK  = 23169;
    localparam int DEF_AMP_QAM1 = 10362;
    localparam int DEF_AMP_QAM3 = 31086;

    // The reserved code 11 falls back to QPSK.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_BPSK;
            2'b10:   return MODE_QAM16;
            default: return MODE_QPSK;
        endcase
    endfunction

    function automatic logic [2:0] bits_per_symbol(input mode_e m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_QAM16: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/mpsk_qam_mapper_if.sv
// Ready/valid stream with an end-of-burst marker.
// Used for both the serial bit input and the I/Q symbol output.
interface mpsk_qam_mapper_if #(
    parameter int W = 1
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/mpsk_qam_mapper_lut.sv
// Combinational symbol-to-constellation lookup.
// Symbol bit 3 is the first received bit (b0).
module mpsk_qam_lut
    import mpsk_qam_mapper_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int AMP_PSK  = DEF_AMP_PSK,
    parameter int AMP_QAM1 = DEF_AMP_QAM1,
    parameter int AMP_QAM3 = DEF_AMP_QAM3
) (
    input  mode_e                 mode,
    input  logic [3:0]            sym,
    output logic [2*SAMPLE_W-1:0] iq
);

    localparam logic [SAMPLE_W-1:0] PSK_P = SAMPLE_W'(AMP_PSK);
    localparam logic [SAMPLE_W-1:0] PSK_N = SAMPLE_W'(-AMP_PSK);
    localparam logic [SAMPLE_W-1:0] Q1_P  = SAMPLE_W'(AMP_QAM1);
    localparam logic [SAMPLE_W-1:0] Q1_N  = SAMPLE_W'(-AMP_QAM1);
    localparam logic [SAMPLE_W-1:0] Q3_P  = SAMPLE_W'(AMP_QAM3);
    localparam logic [SAMPLE_W-1:0] Q3_N  = SAMPLE_W'(-AMP_QAM3);
    localparam logic [SAMPLE_W-1:0] ZERO  = '0;

    // Gray-coded 4-level axis: 00 +3, 01 +1, 11 -1, 10 -3.
    function automatic logic [SAMPLE_W-1:0] gray_lvl(input logic [1:0] b);
        case (b)
            2'b00:   return Q3_P;
            2'b01:   return Q1_P;
            2'b11:   return Q1_N;
            default: return Q3_N;
        endcase
    endfunction

    logic [SAMPLE_W-1:0] i_lvl;
    logic [SAMPLE_W-1:0] q_lvl;

    // Select I and Q levels for the current mode.
    always_comb begin
        i_lvl = ZERO;
        q_lvl = ZERO;
        unique case (mode)
            MODE_BPSK: begin
                i_lvl = sym[3] ? PSK_N : PSK_P;
            end
            MODE_QPSK: begin
                i_lvl = sym[3] ? PSK_N : PSK_P;
                q_lvl = sym[2] ? PSK_N : PSK_P;
            end
            MODE_QAM16: begin
                i_lvl = gray_lvl(sym[3:2]);
                q_lvl = gray_lvl(sym[1:0]);
            end
            default: begin
                i_lvl = ZERO;
                q_lvl = ZERO;
            end
        endcase
    end

    assign iq = {i_lvl, q_lvl};

endmodule

// File: rtl/mpsk_qam_mapper.sv
// Serial bit to I/Q symbol mapper, BPSK/QPSK/16QAM selectable per symbol.
// Holds shift register, bit counter, latched mode and a one-entry output register.
module mpsk_qam_mapper
    import mpsk_qam_mapper_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int AMP_PSK  = DEF_AMP_PSK,
    parameter int AMP_QAM1 = DEF_AMP_QAM1,
    parameter int AMP_QAM3 = DEF_AMP_QAM3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_mode,
    mpsk_qam_mapper_if.slave      s_bit,
    mpsk_qam_mapper_if.master     m_sym
);

    logic [1:0]            cnt;
    logic [3:0]            shreg;
    mode_e                 mode_q;
    logic [2*SAMPLE_W-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    mode_e                 cur_mode;
    logic [2:0]            bps;
    logic [3:0]            sym_nxt;
    logic                  accept;
    logic                  done;
    logic [2*SAMPLE_W-1:0] lut_iq;

    assign s_bit.ready = ~valid_q | m_sym.ready;
    assign accept      = s_bit.valid & s_bit.ready;
    assign cur_mode    = (cnt == 2'd0) ? decode_mode(i_mode) : mode_q;
    assign bps         = bits_per_symbol(cur_mode);
    assign done        = accept & ((({1'b0, cnt} + 3'd1) == bps) | s_bit.last);

    // Insert the incoming bit MSB-first; unreceived bits stay zero for padding.
    always_comb begin
        sym_nxt = (cnt == 2'd0) ? 4'b0000 : shreg;
        sym_nxt[2'd3 - cnt] = s_bit.data[0];
    end

    mpsk_qam_lut #(
        .SAMPLE_W (SAMPLE_W),
        .AMP_PSK  (AMP_PSK),
        .AMP_QAM1 (AMP_QAM1),
        .AMP_QAM3 (AMP_QAM3)
    ) u_lut (
        .mode (cur_mode),
        .sym  (sym_nxt),
        .iq   (lut_iq)
    );

    // Accumulate bits, emit completed symbols, drain the output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            shreg   <= '0;
            mode_q  <= MODE_QPSK;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (cnt == 2'd0) begin
                    mode_q <= cur_mode;
                end
                if (done) begin
                    cnt     <= '0;
                    shreg   <= '0;
                    data_q  <= lut_iq;
                    valid_q <= 1'b1;
                    last_q  <= s_bit.last;
                end else begin
                    cnt   <= cnt + 2'd1;
                    shreg <= sym_nxt;
                end
            end
            if (valid_q & m_sym.ready & ~done) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign m_sym.data  = data_q;
    assign m_sym.valid = valid_q;
    assign m_sym.last  = last_q;

endmodule

// File: tb/tb_mpsk_qam_mapper.sv
// Directed bench for mpsk_qam_mapper.
// Expected symbols are hand-computed 16-bit constants.
module tb_mpsk_qam_mapper;

    localparam logic [15:0] P_PSK = 16'h5A81;
    localparam logic [15:0] N_PSK = 16'hA57F;
    localparam logic [15:0] P1    = 16'h287A;
    localparam logic [15:0] N1    = 16'hD786;
    localparam logic [15:0] P3    = 16'h796E;
    localparam logic [15:0] N3    = 16'h8692;
    localparam logic [15:0] Z     = 16'h0000;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [1:0] i_mode;
    int         checks = 0;
    int         errors = 0;
    logic [33:0] obs;
    logic [33:0] exp_v;
    logic [31:0] held;

    mpsk_qam_mapper_if #(.W(1))  bit_if ();
    mpsk_qam_mapper_if #(.W(32)) sym_if ();

    mpsk_qam_mapper dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_mode  (i_mode),
        .s_bit   (bit_if),
        .m_sym   (sym_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic l);
        bit_if.data  = b;
        bit_if.valid = 1'b1;
        bit_if.last  = l;
        step();
        bit_if.valid = 1'b0;
        bit_if.last  = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        obs = {sym_if.valid, sym_if.last, sym_if.data};
        checks++;
        if (obs !== 34'd0) begin
            errors++;
            $display("FAIL reset_out got %h want %h", obs, 34'd0);
        end
        checks++;
        if (bit_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bit_if.ready);
        end
    endtask

    task automatic test_qpsk();
        i_mode = 2'b01;
        drive(1'b0, 1'b0);
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL qpsk_early got %b want 0", sym_if.valid);
        end
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P_PSK, N_PSK};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL qpsk_sym got %h want %h", obs, exp_v);
        end
        step();
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL qpsk_pulse got %b want 0", sym_if.valid);
        end
    endtask

    task automatic test_bpsk_back_to_back();
        i_mode = 2'b00;
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, N_PSK, Z};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bpsk_0 got %h want %h", obs, exp_v);
        end
        drive(1'b0, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P_PSK, Z};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bpsk_1 got %h want %h", obs, exp_v);
        end
        drive(1'b1, 1'b1);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b1, N_PSK, Z};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bpsk_2_last got %h want %h", obs, exp_v);
        end
        step();
        checks++;
        if ({sym_if.valid, sym_if.last} !== 2'b00) begin
            errors++;
            $display("FAIL bpsk_drain got %b want 00", {sym_if.valid, sym_if.last});
        end
    endtask

    task automatic test_qam16();
        i_mode = 2'b10;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL qam_a_early got %b want 0", sym_if.valid);
        end
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P3, N1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL qam_a got %h want %h", obs, exp_v);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL qam_b_early got %b want 0", sym_if.valid);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, N3, P1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL qam_b got %h want %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_partial();
        i_mode = 2'b10;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b1, N1, P3};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL partial got %h want %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_backpressure();
        i_mode = 2'b01;
        sym_if.ready = 1'b0;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        held = {N_PSK, N_PSK};
        bit_if.data  = 1'b0;
        bit_if.valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            obs = {sym_if.valid, bit_if.ready, sym_if.data};
            checks++;
            if (obs !== {1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL hold_%0d got %h want %h", k, obs, {1'b1, 1'b0, held});
            end
            step();
        end
        sym_if.ready = 1'b1;
        #1;
        checks++;
        if (bit_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b want 1", bit_if.ready);
        end
        step();
        bit_if.valid = 1'b0;
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL release_drain got %b want 0", sym_if.valid);
        end
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P_PSK, N_PSK};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL resume got %h want %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_mode_switch();
        i_mode = 2'b01;
        drive(1'b0, 1'b0);
        i_mode = 2'b10;
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P_PSK, N_PSK};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL switch_qpsk got %h want %h", obs, exp_v);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL switch_qam_early got %b want 0", sym_if.valid);
        end
        i_mode = 2'b00;
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, N1, P1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL switch_qam got %h want %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_reset_mid();
        i_mode = 2'b10;
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        checks++;
        if (sym_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out got %b want 0", sym_if.valid);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (sym_if.valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_bit%0d got %b want 0", k, sym_if.valid);
            end
        end
        drive(1'b0, 1'b0);
        obs   = {sym_if.valid, sym_if.last, sym_if.data};
        exp_v = {1'b1, 1'b0, P3, P3};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_sym got %h want %h", obs, exp_v);
        end
        step();
    endtask

    initial begin
        i_reset      = 1'b1;
        i_mode       = 2'b01;
        bit_if.data  = 1'b0;
        bit_if.valid = 1'b0;
        bit_if.last  = 1'b0;
        sym_if.ready = 1'b1;
        test_reset();
        test_qpsk();
        test_bpsk_back_to_back();
        test_qam16();
        test_partial();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
